// File: rtl/regfile_wb_if.sv
// regfile_wb_if
// Bundles the datapath-facing signals of the register file: write port,
// three read ports, the PC+8 value, the NZCV flag update path and the
// four-phase debug read handshake.
//   master : the core / test harness (drives writes, addresses, debug requests)
//   slave  : the register file (drives read data, flags, debug ack/data)
// Clock and reset are not part of the bundle; they stay plain module ports.
interface regfile_wb_if #(
    parameter int WIDTH = 32
);
    logic             we3;
    logic [3:0]       wa3;
    logic [WIDTH-1:0] wd3;
    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic [3:0]       ra3;
    logic [WIDTH-1:0] r15;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] rd3;
    logic [1:0]       flag_we;
    logic [3:0]       alu_flags;
    logic [3:0]       flags;
    logic             dbg_req;
    logic [3:0]       dbg_addr;
    logic             dbg_ack;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output we3, wa3, wd3, ra1, ra2, ra3, r15, flag_we, alu_flags,
               dbg_req, dbg_addr,
        input  rd1, rd2, rd3, flags, dbg_ack, dbg_data
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, ra3, r15, flag_we, alu_flags,
               dbg_req, dbg_addr,
        output rd1, rd2, rd3, flags, dbg_ack, dbg_data
    );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb
// Write-back side of the ARM single-cycle core register file. Holds R0..R14,
// the NZCV flags with split N/Z and C/V update enables, and a four-phase
// debug read port that snapshots any register without touching the datapath.
// Ports:
//   clk    - core clock, all state changes on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - regfile_wb_if.slave: write port (we3/wa3/wd3), read ports
//            (ra1..ra3 -> rd1..rd3), r15 (PC+8), flag_we/alu_flags -> flags,
//            debug handshake (dbg_req/dbg_addr -> dbg_ack/dbg_data)
// Configuration:
//   REGFILE_BYPASS_EN - when defined, a read (including the debug capture)
//   of the register being written this cycle returns wd3 combinationally.
//   When undefined, reads always return stored contents.
module regfile_wb #(
    parameter int WIDTH = 32,
    parameter int NREGS = 15
) (
    input  logic         clk,
    input  logic         reset,
    regfile_wb_if.slave  bus
);

    typedef enum logic {
        IDLE,
        ACK
    } dbgState_e;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [3:0]       flags_q;
    dbgState_e        dbgState_q;
    dbgState_e        dbgState_d;
    logic [WIDTH-1:0] dbgData_q;
    logic [WIDTH-1:0] dbgData_d;
    logic             writeEn;

    // Address 15 is the PC, which lives outside this block, so a write there
    // is silently dropped.
    assign writeEn = bus.we3 && (bus.wa3 != 4'hF);

    // Shared read mux for all three ports and the debug capture. Address 15
    // always returns the PC+8 value and is never bypassed.
    function automatic logic [WIDTH-1:0] readPort(input logic [3:0] addr);
        logic [WIDTH-1:0] value;
        if (addr == 4'hF) begin
            value = bus.r15;
        end else begin
            value = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (writeEn && (addr == bus.wa3)) begin
                value = bus.wd3;
            end
`endif
        end
        return value;
    endfunction

    // Register array: decode the write address to exactly one register;
    // everything else holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (writeEn && (bus.wa3 == 4'(i))) begin
                    regs_q[i] <= bus.wd3;
                end
            end
        end
    end

    // Flag register: N/Z and C/V halves have independent enables so that
    // logical ops can leave C/V untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (bus.flag_we[1]) begin
                flags_q[3:2] <= bus.alu_flags[3:2];
            end
            if (bus.flag_we[0]) begin
                flags_q[1:0] <= bus.alu_flags[1:0];
            end
        end
    end

    // Debug FSM state and snapshot register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbgState_q <= IDLE;
            dbgData_q  <= '0;
        end else begin
            dbgState_q <= dbgState_d;
            dbgData_q  <= dbgData_d;
        end
    end

    // Debug next-state logic. The snapshot is taken only on the IDLE->ACK
    // edge, so the requester may change dbg_addr once ack is seen and
    // later writes to the sampled register do not disturb dbg_data.
    always_comb begin
        dbgState_d = dbgState_q;
        dbgData_d  = dbgData_q;
        case (dbgState_q)
            IDLE: begin
                if (bus.dbg_req) begin
                    dbgData_d  = readPort(bus.dbg_addr);
                    dbgState_d = ACK;
                end
            end
            ACK: begin
                if (!bus.dbg_req) begin
                    dbgState_d = IDLE;
                end
            end
            default: dbgState_d = IDLE;
        endcase
    end

    assign bus.rd1      = readPort(bus.ra1);
    assign bus.rd2      = readPort(bus.ra2);
    assign bus.rd3      = readPort(bus.ra3);
    assign bus.flags    = flags_q;
    assign bus.dbg_ack  = (dbgState_q == ACK);
    assign bus.dbg_data = dbgData_q;

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb
// Self-checking bench for regfile_wb: directed sequences for reset, write
// decode, R15 handling, flag enables, the debug handshake and bypass, then
// a randomized run compared against a behavioural model built from plain
// arrays.
module tb_regfile_wb;

    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_wb_if #(.WIDTH(WIDTH)) bus ();

    regfile_wb #(
        .WIDTH(WIDTH),
        .NREGS(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] expected;
    } readVec_t;

    // Behavioural model state for the randomized phase
    logic [31:0] modelRegs [15];
    logic [3:0]  modelFlags;
    logic        modelAck;
    logic [31:0] modelDbgData;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa,
                                 input logic [31:0] wd, input logic [1:0] fwe,
                                 input logic [3:0] alu);
        bus.we3       = we;
        bus.wa3       = wa;
        bus.wd3       = wd;
        bus.flag_we   = fwe;
        bus.alu_flags = alu;
    endtask

    task automatic setReads(input logic [3:0] a1, input logic [3:0] a2,
                            input logic [3:0] a3);
        bus.ra1 = a1;
        bus.ra2 = a2;
        bus.ra3 = a3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model read: PC for address 15, optional write-through, else stored value
    function automatic logic [31:0] modelRead(input logic [3:0] a);
        if (a == 4'hF) return bus.r15;
`ifdef REGFILE_BYPASS_EN
        if (bus.we3 && bus.wa3 != 4'hF && a == bus.wa3) return bus.wd3;
`endif
        return modelRegs[a];
    endfunction

    initial begin
        readVec_t    decodeTable [16];
        logic [31:0] bypassExp;
        logic        nextAck;
        logic [31:0] nextDbg;
        logic [3:0]  nextFlags;
        logic        doWrite;
        logic [3:0]  writeAddr;
        logic [31:0] writeData;

        checks = 0;
        errors = 0;

        for (int i = 0; i < 16; i++) begin
            decodeTable[i].addr     = 4'(i);
            decodeTable[i].expected = (i == 5)  ? 32'hDEADBEEF :
                                      (i == 15) ? 32'h00000108 : 32'h0;
        end

        // ---- Reset state ----
        reset = 1'b1;
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0000);
        setReads(4'd3, 4'd0, 4'd14);
        bus.r15      = 32'h0;
        bus.dbg_req  = 1'b0;
        bus.dbg_addr = 4'd0;
        tick();
        checkOutput("reset_rd1", bus.rd1, 32'h0);
        checkOutput("reset_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("reset_ack", {31'h0, bus.dbg_ack}, 32'h0);
        checkOutput("reset_dbgdata", bus.dbg_data, 32'h0);
        reset = 1'b0;

        // ---- Asynchronous reset mid-operation ----
        tick();
        applyStimulus(1'b1, 4'd3, 32'h12345678, 2'b11, 4'b1010);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0000);
        #1;
        checkOutput("midop_r3", bus.rd1, 32'h12345678);
        checkOutput("midop_flags", {28'h0, bus.flags}, 32'h0000000A);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_r3", bus.rd1, 32'h0);
        checkOutput("async_reset_flags", {28'h0, bus.flags}, 32'h0);
        #1 reset = 1'b0;

        // ---- Write decode across all 16 addresses ----
        tick();
        bus.r15 = 32'h00000108;
        applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 2'b00, 4'b0000);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            setReads(decodeTable[i].addr, decodeTable[i].addr, decodeTable[i].addr);
            #1;
            checkOutput($sformatf("decode_rd1_a%0d", i), bus.rd1, decodeTable[i].expected);
            checkOutput($sformatf("decode_rd2_a%0d", i), bus.rd2, decodeTable[i].expected);
            checkOutput($sformatf("decode_rd3_a%0d", i), bus.rd3, decodeTable[i].expected);
        end

        // ---- Writes to address 15 are dropped ----
        tick();
        bus.r15 = 32'h00000200;
        applyStimulus(1'b1, 4'hF, 32'hFFFFFFFF, 2'b00, 4'b0000);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0000);
        setReads(4'hF, 4'hF, 4'hF);
        #1;
        checkOutput("r15_rd1", bus.rd1, 32'h200);
        checkOutput("r15_rd2", bus.rd2, 32'h200);
        checkOutput("r15_rd3", bus.rd3, 32'h200);
        for (int i = 0; i < 15; i++) begin
            setReads(4'(i), 4'd0, 4'd0);
            #1;
            checkOutput($sformatf("r15_hold_a%0d", i), bus.rd1,
                        (i == 5) ? 32'hDEADBEEF : 32'h0);
        end

        // ---- Split flag enables ----
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b10, 4'b1111);
        tick();
        checkOutput("flags_nz", {28'h0, bus.flags}, 32'h0000000C);
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b01, 4'b0001);
        tick();
        checkOutput("flags_cv", {28'h0, bus.flags}, 32'h0000000D);
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0110);
        tick();
        checkOutput("flags_hold", {28'h0, bus.flags}, 32'h0000000D);

        // ---- Debug handshake ----
        applyStimulus(1'b1, 4'd7, 32'hA5A5A5A5, 2'b00, 4'b0000);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0000);
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 4'd7;
        #1;
        checkOutput("dbg_ack_before", {31'h0, bus.dbg_ack}, 32'h0);
        tick();
        bus.dbg_addr = 4'd0;
        checkOutput("dbg_ack_rise", {31'h0, bus.dbg_ack}, 32'h1);
        checkOutput("dbg_data_capture", bus.dbg_data, 32'hA5A5A5A5);
        applyStimulus(1'b1, 4'd7, 32'h0, 2'b00, 4'b0000);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0000);
        setReads(4'd7, 4'd0, 4'd0);
        #1;
        checkOutput("dbg_r7_cleared", bus.rd1, 32'h0);
        checkOutput("dbg_ack_held", {31'h0, bus.dbg_ack}, 32'h1);
        checkOutput("dbg_data_stable", bus.dbg_data, 32'hA5A5A5A5);
        bus.dbg_req = 1'b0;
        tick();
        checkOutput("dbg_ack_fall", {31'h0, bus.dbg_ack}, 32'h0);
        checkOutput("dbg_data_kept", bus.dbg_data, 32'hA5A5A5A5);

        // ---- Reset during ACK drops ack immediately ----
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 4'd5;
        tick();
        checkOutput("dbg_ack_r5", {31'h0, bus.dbg_ack}, 32'h1);
        checkOutput("dbg_data_r5", bus.dbg_data, 32'hDEADBEEF);
        #2 reset = 1'b1;
        #1;
        checkOutput("dbg_ack_reset", {31'h0, bus.dbg_ack}, 32'h0);
        checkOutput("dbg_data_reset", bus.dbg_data, 32'h0);
        bus.dbg_req = 1'b0;
        #1 reset = 1'b0;

        // ---- Same-cycle read of the register being written ----
        tick();
`ifdef REGFILE_BYPASS_EN
        bypassExp = 32'h55;
`else
        bypassExp = 32'h0;
`endif
        applyStimulus(1'b1, 4'd2, 32'h55, 2'b00, 4'b0000);
        setReads(4'd2, 4'd0, 4'd0);
        #1;
        checkOutput("bypass_same_cycle", bus.rd1, bypassExp);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 2'b00, 4'b0000);
        #1;
        checkOutput("bypass_next_cycle", bus.rd1, 32'h55);

        // ---- Randomized run against the behavioural model ----
        reset = 1'b1;
        bus.dbg_req = 1'b0;
        #2 reset = 1'b0;
        for (int i = 0; i < 15; i++) modelRegs[i] = 32'h0;
        modelFlags   = 4'b0000;
        modelAck     = 1'b0;
        modelDbgData = 32'h0;
        tick();

        for (int cyc = 0; cyc < 400; cyc++) begin
            doWrite   = ($urandom_range(0, 3) != 0);
            writeAddr = 4'($urandom_range(0, 15));
            writeData = $urandom;
            applyStimulus(doWrite, writeAddr, writeData,
                          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            setReads(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) == 1) ? writeAddr : 4'($urandom_range(0, 15)));
            bus.r15      = $urandom;
            bus.dbg_req  = ($urandom_range(0, 1) == 1);
            bus.dbg_addr = ($urandom_range(0, 1) == 1) ? writeAddr : 4'($urandom_range(0, 15));
            #1;
            checkOutput("rand_rd1", bus.rd1, modelRead(bus.ra1));
            checkOutput("rand_rd2", bus.rd2, modelRead(bus.ra2));
            checkOutput("rand_rd3", bus.rd3, modelRead(bus.ra3));

            // Predict the state after this edge from pre-edge values
            nextFlags = modelFlags;
            if (bus.flag_we[1]) nextFlags[3:2] = bus.alu_flags[3:2];
            if (bus.flag_we[0]) nextFlags[1:0] = bus.alu_flags[1:0];
            nextAck = modelAck;
            nextDbg = modelDbgData;
            if (!modelAck && bus.dbg_req) begin
                nextAck = 1'b1;
                nextDbg = modelRead(bus.dbg_addr);
            end else if (modelAck && !bus.dbg_req) begin
                nextAck = 1'b0;
            end

            tick();
            if (doWrite && writeAddr != 4'hF) modelRegs[writeAddr] = writeData;
            modelFlags   = nextFlags;
            modelAck     = nextAck;
            modelDbgData = nextDbg;
            checkOutput("rand_flags", {28'h0, bus.flags}, {28'h0, modelFlags});
            checkOutput("rand_ack", {31'h0, bus.dbg_ack}, {31'h0, modelAck});
            checkOutput("rand_dbgdata", bus.dbg_data, modelDbgData);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
